// File: rtl/button_debouncer.sv
// Button/switch debouncer: multi-flop synchronizer, then a 4-state stability FSM with registered level and edge pulses.
// Optional long-press detector enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 50000,
    parameter int CNT_WIDTH    = 16
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    ,
    parameter int LONG_COUNT   = 1000000,
    parameter int LONG_WIDTH   = 20
`endif
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn_In,
    output logic D,
    output logic Rise,
    output logic Fall,
    output logic Busy
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    ,
    output logic Long_Press
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit                   ONE_SHOT = (STABLE_COUNT == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out_s;
    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   d_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    assign sync_out_s = sync_q[SYNC_STAGES-1];

    // Synchronizer shift chain for the asynchronous button level
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Btn_In};
        end
    end

    // Stability FSM; a bounce is tested before the count compare so it always aborts
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_out_s) begin
                        if (ONE_SHOT) begin
                            state_q <= IDLE_HIGH;
                            d_q     <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_HIGH;
                            cnt_q   <= CNT_ONE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_out_s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        d_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_out_s) begin
                        if (ONE_SHOT) begin
                            state_q <= IDLE_LOW;
                            d_q     <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_LOW;
                            cnt_q   <= CNT_ONE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (sync_out_s) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        d_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    d_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign D    = d_q;
    assign Rise = rise_q;
    assign Fall = fall_q;
    assign Busy = busy_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] HOLD_MAX = LONG_WIDTH'(LONG_COUNT);
    localparam logic [LONG_WIDTH-1:0] HOLD_ONE = LONG_WIDTH'(1);

    logic [LONG_WIDTH-1:0] hold_q;
    logic                  long_q;

    // Hold counter saturates at the threshold, so the pulse fires once per press
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else if (!d_q) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HOLD_ONE;
            long_q <= (hold_q == (HOLD_MAX - HOLD_ONE));
        end else begin
            long_q <= 1'b0;
        end
    end

    assign Long_Press = long_q;
`endif

endmodule
